// File: rtl/ovr_mon_pkg.sv
// Shared types, default constants and width helper for the over-current monitor.
package ovr_mon_pkg;

  typedef enum logic {
    MON    = 1'b0,
    SHTDWN = 1'b1
  } ovr_state_e;

  localparam int DEF_BLANK_CYC     = 128;
  localparam int DEF_FAULT_LIMIT   = 10;
  localparam int DEF_RETRY_PERIODS = 1024;

  // Bits needed to hold the values 0..n-1 (never less than one).
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ovr_ch_filt.sv
// One monitored bridge: input synchroniser, blanked seen flag, saturating
// up/down fault counter and sticky fault flag.
module ovr_ch_filt #(
  parameter int FAULT_LIMIT = 10,
  parameter int CW          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ovr,
  input  logic i_win,
  input  logic i_pwm,
  input  logic i_en,
  input  logic i_clr,
  output logic o_seen,
  output logic o_fault,
  output logic o_fault_set
);

  localparam logic [CW-1:0] LIM = CW'(FAULT_LIMIT);

  logic [1:0]    r_sync;
  logic          r_seen;
  logic          r_fault;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_ovr};

  // The pwm_synch cycle itself is never sampled: seen is consumed and cleared there.
  always_ff @(posedge clk or posedge rst)
    if (rst)                           r_seen <= 1'b0;
    else if (i_clr || i_pwm || !i_en)  r_seen <= 1'b0;
    else if (i_win && r_sync[1])       r_seen <= 1'b1;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_en) w_cnt_nxt = '0;
    else if (i_pwm) begin
      if (r_seen && r_cnt != LIM)        w_cnt_nxt = r_cnt + 1'b1;
      else if (!r_seen && r_cnt != '0)  w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  assign o_fault_set = (w_cnt_nxt == LIM) && !r_fault;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (o_fault_set) r_fault <= 1'b1;
    end

  assign o_seen  = r_seen;
  assign o_fault = r_fault;

endmodule

// File: rtl/ovr_i_mon.sv
// N-channel over-current monitor: shared blanking window, first-fault capture,
// shutdown FSM with optional auto-retry after a run of quiet PWM periods.
module ovr_i_mon
  import ovr_mon_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int BLANK_CYC     = DEF_BLANK_CYC,
  parameter int FAULT_LIMIT   = DEF_FAULT_LIMIT,
  parameter int AUTO_RETRY    = 0,
  parameter int RETRY_PERIODS = DEF_RETRY_PERIODS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pwm_synch,
  input  logic [NUM_CH-1:0]         ovr_i,
  input  logic                      en,
  input  logic                      clr_fault,
  output logic                      OVR_I_shtdwn,
  output logic [NUM_CH-1:0]         fault,
  output logic [$clog2(NUM_CH)-1:0] first_fault
);

  localparam int BW = cw(BLANK_CYC + 1);
  localparam int CW = cw(FAULT_LIMIT + 1);
  localparam int RW = cw(RETRY_PERIODS);
  localparam int FW = $clog2(NUM_CH);

  logic [BW-1:0]     r_blank;
  logic              w_win;
  logic [NUM_CH-1:0] w_seen;
  logic [NUM_CH-1:0] w_fset;
  logic [RW-1:0]     r_retry;
  logic              w_retry_done;
  logic              w_clr;
  logic [FW-1:0]     r_first;
  logic [FW-1:0]     w_first_idx;
  ovr_state_e        r_state;
  ovr_state_e        w_state_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst)                            r_blank <= BW'(BLANK_CYC);
    else if (pwm_synch)                 r_blank <= '0;
    else if (r_blank != BW'(BLANK_CYC)) r_blank <= r_blank + 1'b1;

  assign w_win = (r_blank == BW'(BLANK_CYC));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ovr_ch_filt #(
      .FAULT_LIMIT (FAULT_LIMIT),
      .CW          (CW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_ovr       (ovr_i[g]),
      .i_win       (w_win),
      .i_pwm       (pwm_synch),
      .i_en        (en),
      .i_clr       (w_clr),
      .o_seen      (w_seen[g]),
      .o_fault     (fault[g]),
      .o_fault_set (w_fset[g])
    );
  end

  assign w_retry_done = (AUTO_RETRY != 0) && (r_state == SHTDWN) && pwm_synch &&
                        !(|w_seen) && (r_retry == RW'(RETRY_PERIODS - 1));
  assign w_clr        = clr_fault || w_retry_done;

  always_ff @(posedge clk or posedge rst)
    if (rst)                                                  r_retry <= '0;
    else if (w_clr || r_state != SHTDWN || AUTO_RETRY == 0)   r_retry <= '0;
    else if (pwm_synch)                                       r_retry <= (|w_seen) ? '0 : r_retry + 1'b1;

  // Lowest index wins when several channels trip on the same pwm_synch.
  always_comb begin
    w_first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_fset[i]) w_first_idx = FW'(i);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)                          r_first <= '0;
    else if (w_clr)                   r_first <= '0;
    else if (!(|fault) && |w_fset)    r_first <= w_first_idx;

  assign first_fault = r_first;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= MON;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MON:     if (|fault && !w_clr) w_state_nxt = SHTDWN;
      SHTDWN:  if (w_clr)            w_state_nxt = MON;
      default:                       w_state_nxt = MON;
    endcase
  end

  always_comb OVR_I_shtdwn = (r_state == SHTDWN);

endmodule

// File: tb/tb_ovr_i_mon.sv
// Bench for ovr_i_mon: a latched and an auto-retry instance share stimulus and
// are each checked against a per-PWM-period behavioural model.
module tb_ovr_i_mon;

  localparam int NC  = 2;
  localparam int BC  = 8;
  localparam int FL  = 4;
  localparam int RP  = 3;
  localparam int PER = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_synch = 1'b0;
  logic          en = 1'b1;
  logic          clr_fault = 1'b0;
  logic [NC-1:0] ovr_i = '0;
  logic          sh_l, sh_a;
  logic [NC-1:0] flt_l, flt_a;
  logic [0:0]    ff_l, ff_a;

  int n_chk = 0;
  int n_pass = 0;

  // Model state, index 0 = latched instance, 1 = auto-retry instance.
  int            m_cnt [2][NC];
  logic [NC-1:0] m_fault [2];
  int            m_first [2];
  int            m_retry [2];
  bit            exp_sh1 [2];
  logic [NC-1:0] p_lvl;
  bit            p_en;
  logic [4:0]    obs [2];

  ovr_i_mon #(.NUM_CH(NC), .BLANK_CYC(BC), .FAULT_LIMIT(FL), .AUTO_RETRY(0), .RETRY_PERIODS(RP)) u_lat (
    .clk(clk), .rst(rst), .pwm_synch(pwm_synch), .ovr_i(ovr_i), .en(en), .clr_fault(clr_fault),
    .OVR_I_shtdwn(sh_l), .fault(flt_l), .first_fault(ff_l));

  ovr_i_mon #(.NUM_CH(NC), .BLANK_CYC(BC), .FAULT_LIMIT(FL), .AUTO_RETRY(1), .RETRY_PERIODS(RP)) u_ar (
    .clk(clk), .rst(rst), .pwm_synch(pwm_synch), .ovr_i(ovr_i), .en(en), .clr_fault(clr_fault),
    .OVR_I_shtdwn(sh_a), .fault(flt_a), .first_fault(ff_a));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) m_cnt[d][c] = 0;
      m_fault[d] = '0;
      m_first[d] = 0;
      m_retry[d] = 0;
      exp_sh1[d] = 1'b0;
    end
    p_lvl = ovr_i;
    p_en  = en;
  endtask

  // One pwm_synch: consume the ending period's seen, apply counts, faults, retry.
  task automatic model_pwm(input bit clr, input logic [NC-1:0] nlvl);
    for (int d = 0; d < 2; d++) begin
      bit            sht, rclr;
      logic [NC-1:0] sn, nw;
      sht  = (m_fault[d] != '0);
      rclr = 1'b0;
      nw   = '0;
      sn   = p_en ? p_lvl : '0;
      if (!clr) begin
        if (d == 1 && sht) begin
          m_retry[d] = (sn != '0) ? 0 : m_retry[d] + 1;
          rclr = (m_retry[d] == RP);
        end
        for (int c = 0; c < NC; c++) begin
          if (!en)        m_cnt[d][c] = 0;
          else if (sn[c]) m_cnt[d][c] = (m_cnt[d][c] < FL) ? m_cnt[d][c] + 1 : FL;
          else            m_cnt[d][c] = (m_cnt[d][c] > 0) ? m_cnt[d][c] - 1 : 0;
          nw[c] = (m_cnt[d][c] == FL);
        end
        if (m_fault[d] == '0 && nw != '0)
          for (int c = NC - 1; c >= 0; c--) if (nw[c]) m_first[d] = c;
        m_fault[d] |= nw;
      end
      if (clr || rclr) begin
        for (int c = 0; c < NC; c++) m_cnt[d][c] = 0;
        m_fault[d] = '0;
        m_first[d] = 0;
        m_retry[d] = 0;
      end
      exp_sh1[d] = sht && !clr && !rclr;
    end
    p_lvl = nlvl;
    p_en  = en;
  endtask

  // Expected {shutdown 1 clk after pwm, fault, first_fault, shutdown 2 clks after pwm}.
  function automatic logic [4:0] exp_v(input int d);
    logic [0:0] f;
    f = 1'(m_first[d]);
    return {exp_sh1[d], m_fault[d], f, (m_fault[d] != '0)};
  endfunction

  // Drives one PWM period; a short period never opens the window, so it counts as quiet.
  task automatic run_period(input logic [NC-1:0] lvl, input bit blank, input bit clr, input int len);
    pwm_synch = 1'b1;
    clr_fault = clr;
    ovr_i     = lvl;
    model_pwm(clr, (blank || len < 16) ? '0 : lvl);
    tick;
    obs[0][4:1] = {sh_l, flt_l, ff_l};
    obs[1][4:1] = {sh_a, flt_a, ff_a};
    pwm_synch = 1'b0;
    clr_fault = 1'b0;
    tick;
    obs[0][0] = sh_l;
    obs[1][0] = sh_a;
    for (int k = 2; k < len; k++) begin
      if (blank && k == 7) ovr_i = '0;
      tick;
    end
  endtask

  task automatic test_reset;
    tick;
    n_chk++;
    if ({sh_l, flt_l, ff_l, sh_a, flt_a, ff_a} !== 8'h00)
      $display("FAIL reset_state: got %b want 00000000", {sh_l, flt_l, ff_l, sh_a, flt_a, ff_a});
    else n_pass++;
    rst   = 1'b0;
    ovr_i = 2'b01;
    model_reset();
    for (int k = 0; k < 10; k++) tick;
    for (int p = 0; p < 3; p++) begin
      run_period(2'b00, 1'b0, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL reset_window inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
  endtask

  task automatic test_blanking;
    for (int p = 0; p < 10; p++) begin
      run_period(2'b01, 1'b1, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL blanking inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
  endtask

  task automatic test_trip;
    for (int p = 0; p < 6; p++) begin
      run_period(2'b10, 1'b0, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL trip inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
      if (p == 4) begin
        n_chk++;
        if (obs[0] !== 5'b0_10_1_1) $display("FAIL trip_latency per%0d: got %b want 01011", p, obs[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_latched_clear;
    for (int p = 0; p < 16; p++) begin
      run_period((p >= 11) ? 2'b01 : 2'b00, 1'b0, (p == 10), PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL latched_clear inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
      if (p == 9 || p == 10) begin
        n_chk++;
        if (obs[0][0] !== (p == 9)) $display("FAIL clr_shutdown per%0d: got %b want %b", p, obs[0][0], (p == 9));
        else n_pass++;
      end
    end
  endtask

  task automatic test_leak;
    run_period(2'b00, 1'b0, 1'b1, PER);
    for (int p = 0; p < 20; p++) begin
      run_period((p % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL leak inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
    n_chk++;
    if (flt_l !== 2'b00) $display("FAIL leak_nofault: got %b want 00", flt_l);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    run_period(2'b00, 1'b0, 1'b1, PER);
    for (int p = 0; p < 6; p++) begin
      run_period(2'b11, 1'b0, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL simultaneous inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
    n_chk++;
    if ({flt_l, ff_l} !== 3'b110) $display("FAIL simul_first: got %b want 110", {flt_l, ff_l});
    else n_pass++;
  endtask

  task automatic test_short_and_en;
    run_period(2'b00, 1'b0, 1'b1, PER);
    for (int p = 0; p < 20; p++) begin
      en = !(p >= 8 && p < 14);
      run_period(2'b11, 1'b0, 1'b0, (p < 8) ? 6 : PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL short_en inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
    en = 1'b1;
  endtask

  task automatic test_retry_restart;
    run_period(2'b00, 1'b0, 1'b1, PER);
    for (int p = 0; p < 13; p++) begin
      run_period((p < 5 || p == 7) ? 2'b01 : 2'b00, 1'b0, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL retry inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
      if (p == 10 || p == 11) begin
        n_chk++;
        if (obs[1][0] !== (p == 10)) $display("FAIL retry_restart per%0d: got %b want %b", p, obs[1][0], (p == 10));
        else n_pass++;
      end
    end
  endtask

  task automatic test_rst_mid_retry;
    run_period(2'b00, 1'b0, 1'b1, PER);
    for (int p = 0; p < 7; p++) run_period((p < 5) ? 2'b10 : 2'b00, 1'b0, 1'b0, PER);
    run_period(2'b00, 1'b0, 1'b0, 30);
    n_chk++;
    if (sh_a !== (m_fault[1] != '0)) $display("FAIL pre_rst_shutdown: got %b want %b", sh_a, (m_fault[1] != '0));
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({sh_l, flt_l, ff_l, sh_a, flt_a, ff_a} !== 8'h00)
      $display("FAIL async_rst: got %b want 00000000", {sh_l, flt_l, ff_l, sh_a, flt_a, ff_a});
    else n_pass++;
    tick;
    tick;
    rst = 1'b0;
    model_reset();
    tick;
    for (int p = 0; p < 6; p++) begin
      run_period(2'b10, 1'b0, 1'b0, PER);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL post_rst inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random;
    logic [NC-1:0] lvl;
    bit            blank, clr;
    int            len;
    run_period(2'b00, 1'b0, 1'b1, PER);
    for (int p = 0; p < 60; p++) begin
      for (int c = 0; c < NC; c++) lvl[c] = ($urandom_range(0, 2) != 0);
      blank = ($urandom_range(0, 4) == 0);
      clr   = ($urandom_range(0, 11) == 0);
      en    = ($urandom_range(0, 7) != 0);
      len   = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 7) : $urandom_range(16, 70);
      run_period(lvl, blank, clr, len);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs[d] !== exp_v(d)) $display("FAIL random inst%0d per%0d: got %b want %b", d, p, obs[d], exp_v(d));
        else n_pass++;
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_trip();
    test_latched_clear();
    test_leak();
    test_simultaneous();
    test_short_and_en();
    test_retry_restart();
    test_rst_mid_retry();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ovr_i_mon.md
# ovr_i_mon

Parametrised N-channel motor over-current monitor that generates the shutdown request consumed by the motor drive. Raw comparator flags from each bridge are synchronised and blanked after every PWM period start. Each channel has a saturating up/down fault counter. Channels are ORed into a single registered shutdown, which is either latched until cleared or cleared automatically after a quiet retry interval.

## Interface
- NUM_CH, 2: number of monitored bridges; legal range 2..8.
- BLANK_CYC, 128: clocks after each pwm_synch during which ovr_i is ignored (switching-transient blanking).
- FAULT_LIMIT, 10: per-channel count at which that channel faults; legal range 1..255.
- AUTO_RETRY, 0: 0 = latched until clr_fault; 1 = self-clearing after RETRY_PERIODS quiet periods.
- RETRY_PERIODS, 1024: quiet PWM periods required for auto-retry; must be ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pwm_synch  in  1  one-clock pulse marking the start of each PWM period.
- ovr_i  in  NUM_CH  raw asynchronous over-current flags, one per bridge.
- en  in  1  monitor enable.
- clr_fault  in  1  one-clock pulse clearing faults, counters and shutdown.
- OVR_I_shtdwn  out  1  registered shutdown request to the drive.
- fault  out  NUM_CH  registered per-channel fault flags.
- first_fault  out  $clog2(NUM_CH)  index of the first channel to fault since the last clear.

## Operation
- Each ovr_i bit passes through a 2-flop synchroniser.
- Blank counter:
  - Cleared on pwm_synch; saturates at BLANK_CYC.
  - Window is open when the counter equals BLANK_CYC.
- Per-channel seen flag:
  - Set when the window is open, the synchronised ovr_i is high, and en is high.
- Count update on each pwm_synch, per channel:
  - seen=1: count++ (saturating at FAULT_LIMIT).
  - seen=0: count-- (saturating at 0).
  - seen is cleared in the same cycle.
- A channel faults when its count reaches FAULT_LIMIT.
- first_fault:
  - Captures the lowest-index newly faulting channel, only if no fault is already set.
  - Holds until clear.
- State machine (enum in package):
  - MON: OVR_I_shtdwn=0. Go to SHTDWN when any fault is set.
  - SHTDWN: OVR_I_shtdwn=1.
    - clr_fault: go to MON.
    - AUTO_RETRY=1: retry counter increments on each pwm_synch where no channel's seen is set. It resets to 0 on any seen. On reaching RETRY_PERIODS, faults, counts and first_fault clear and the FSM goes to MON.
- en=0: seen flags and counts are held at 0. Existing fault and SHTDWN state remain.
- clr_fault: clears counts, seen, fault, first_fault and the retry counter, and returns to MON. It has priority over a simultaneous pwm_synch or ovr_i.

## Timing
- Reset values: OVR_I_shtdwn=0, fault=0, first_fault=0, all counts 0, FSM=MON, blank counter=BLANK_CYC (window open until the first pwm_synch).
- Input latency: ovr_i to seen takes 3 clocks (2 synchroniser clocks + seen register).
- Fault latency: fault asserts 1 clock after the pwm_synch that brings the count to FAULT_LIMIT. OVR_I_shtdwn asserts 1 clock after fault.
- Blanking edge cases:
  - A sample on the pwm_synch cycle itself is blanked; the counter is being cleared that cycle.
  - The window reopens exactly BLANK_CYC clocks after pwm_synch.
- A period shorter than BLANK_CYC never opens the window, so no counting occurs.
- Two channels reaching the limit on the same pwm_synch: first_fault = lower index.
- clr_fault asserted while ovr_i is still high: the clear completes. Counting restarts from 0 with the next sampled window.
- Asynchronous rst mid-period returns every register to its reset value immediately.

## Structure
- ovr_mon_pkg:
  - state enum (MON, SHTDWN).
  - Default constants for BLANK_CYC, FAULT_LIMIT and RETRY_PERIODS.
  - Width helper function (clog2-based).
- Sub-module ovr_ch_filt, generated NUM_CH times: synchroniser, seen flag, saturating counter, fault output.
- Top level holds the shared blank counter, first-fault priority encoder, FSM and retry counter.

## Test plan
All tests use NUM_CH=2, BLANK_CYC=8, FAULT_LIMIT=4, RETRY_PERIODS=3, and a 64-clock PWM period.

- Blanking: ovr_i[0] pulses high only during clocks 0..6 after pwm_synch for 10 periods. Expect fault=0 and OVR_I_shtdwn=0.
- Trip: ovr_i[1] held high. Expect fault=2'b10 one clock after the 4th pwm_synch, OVR_I_shtdwn=1 the clock after, and first_fault=1.
- Leak: ovr_i[0] alternates high/low by period for 20 periods (count oscillates 0/1). Expect no fault.
- Simultaneous: both channels held high from the same period. Expect fault=2'b11 and first_fault=0.
- Latched clear (AUTO_RETRY=0): after a trip, drop ovr_i and wait 10 periods; expect shutdown held. Pulse clr_fault coincident with pwm_synch; expect shutdown=0 and all counts=0 on the next clock.
- Auto-retry (AUTO_RETRY=1):
  - After a trip, ovr_i goes low. Expect shutdown to clear after the 3rd quiet pwm_synch.
  - Assert ovr_i for one period mid-retry. Expect the retry counter to restart.
  - Assert rst mid-retry. Expect immediate return to reset values.
